// File: rtl/inert_spi_seq.sv
// Inertial-sensor SPI sequencer: power-up wait, three config writes, then INT-driven yaw read bursts.
// Optional macro PITCH_RD_EN extends each burst with PITCHL/PITCHH reads and adds the pitch_rt output.
module inert_spi_seq #(
   parameter int unsigned PWRUP_W = 16,
   parameter logic [15:0] CFG0    = 16'h0D02,
   parameter logic [15:0] CFG1    = 16'h1160,
   parameter logic [15:0] CFG2    = 16'h1440
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   output logic [15:0] yaw_rt,
   output logic        vld,
   output logic        cfg_done
`ifdef PITCH_RD_EN
   ,
   output logic [15:0] pitch_rt
`endif
);

   localparam logic [2:0] S_PWRUP = 3'd0;
   localparam logic [2:0] S_CFG   = 3'd1;
   localparam logic [2:0] S_CFGW  = 3'd2;
   localparam logic [2:0] S_IDLE  = 3'd3;
   localparam logic [2:0] S_RD    = 3'd4;
   localparam logic [2:0] S_RDW   = 3'd5;

`ifdef PITCH_RD_EN
   localparam int N_RD = 4;
`else
   localparam int N_RD = 2;
`endif
   localparam logic [1:0] LAST_RD = 2'(N_RD - 1);

   logic [2:0]         r_state;
   logic [2:0]         w_state_next;
   logic [PWRUP_W-1:0] r_pwr_cnt;
   logic [1:0]         r_cfg_idx, w_cfg_idx_next;
   logic [1:0]         r_rd_idx, w_rd_idx_next;
   logic               r_int_meta, r_int_sync, r_int_prev, r_pending;
   logic               w_int_rise;
   logic               r_spi_wrt, w_load;
   logic [15:0]        r_spi_cmd, w_cmd_next;
   logic               r_cfg_done, w_cfg_fin;
   logic               w_burst_start, w_capture, w_burst_last;
   logic [15:0]        r_yaw;
   logic               r_vld;
   logic               w_rd_hi_unused;

   assign w_rd_hi_unused = ^spi_rd_data[15:8];

   function automatic logic [15:0] cfg_word(input logic [1:0] idx);
      case (idx)
         2'd0:    cfg_word = CFG0;
         2'd1:    cfg_word = CFG1;
         default: cfg_word = CFG2;
      endcase
   endfunction

   // Read commands: bit15 = read, register address in [14:8]
   function automatic logic [15:0] rd_word(input logic [1:0] idx);
      case (idx)
         2'd0:    rd_word = 16'hA600;
         2'd1:    rd_word = 16'hA700;
         2'd2:    rd_word = 16'hA200;
         default: rd_word = 16'hA300;
      endcase
   endfunction

   assign w_int_rise = r_int_sync & ~r_int_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int_meta <= 1'b0;
         r_int_sync <= 1'b0;
         r_int_prev <= 1'b0;
         r_pending  <= 1'b0;
      end else begin
         r_int_meta <= INT;
         r_int_sync <= r_int_meta;
         r_int_prev <= r_int_sync;
         // A rise coinciding with a burst start is kept for the following burst
         if (w_int_rise)
            r_pending <= 1'b1;
         else if (w_burst_start)
            r_pending <= 1'b0;
      end
   end

   // spi_wrt is high exactly while in CFG or RD, so done is never examined in the pulse cycle
   always_comb begin
      w_state_next   = r_state;
      w_cfg_idx_next = r_cfg_idx;
      w_rd_idx_next  = r_rd_idx;
      w_cmd_next     = r_spi_cmd;
      w_load         = 1'b0;
      w_cfg_fin      = 1'b0;
      w_burst_start  = 1'b0;
      w_capture      = 1'b0;
      w_burst_last   = 1'b0;
      case (r_state)
         S_PWRUP: begin
            if (&r_pwr_cnt) begin
               w_state_next   = S_CFG;
               w_cfg_idx_next = 2'd0;
               w_cmd_next     = cfg_word(2'd0);
               w_load         = 1'b1;
            end
         end
         S_CFG: w_state_next = S_CFGW;
         S_CFGW: begin
            if (spi_done) begin
               if (r_cfg_idx == 2'd2) begin
                  w_state_next = S_IDLE;
                  w_cfg_fin    = 1'b1;
               end else begin
                  w_cfg_idx_next = r_cfg_idx + 2'd1;
                  w_cmd_next     = cfg_word(r_cfg_idx + 2'd1);
                  w_state_next   = S_CFG;
                  w_load         = 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (r_pending) begin
               w_state_next  = S_RD;
               w_rd_idx_next = 2'd0;
               w_cmd_next    = rd_word(2'd0);
               w_load        = 1'b1;
               w_burst_start = 1'b1;
            end
         end
         S_RD: w_state_next = S_RDW;
         S_RDW: begin
            if (spi_done) begin
               w_capture = 1'b1;
               if (r_rd_idx == LAST_RD) begin
                  w_state_next = S_IDLE;
                  w_burst_last = 1'b1;
               end else begin
                  w_rd_idx_next = r_rd_idx + 2'd1;
                  w_cmd_next    = rd_word(r_rd_idx + 2'd1);
                  w_state_next  = S_RD;
                  w_load        = 1'b1;
               end
            end
         end
         default: w_state_next = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_PWRUP;
         r_pwr_cnt  <= '0;
         r_cfg_idx  <= 2'd0;
         r_rd_idx   <= 2'd0;
         r_spi_wrt  <= 1'b0;
         r_spi_cmd  <= 16'h0000;
         r_cfg_done <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cfg_idx <= w_cfg_idx_next;
         r_rd_idx  <= w_rd_idx_next;
         r_spi_wrt <= w_load;
         r_spi_cmd <= w_cmd_next;
         if (r_state == S_PWRUP)
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
         if (w_cfg_fin)
            r_cfg_done <= 1'b1;
      end
   end

   // Holding bytes for every read except the last; the last byte goes straight to the outputs
   genvar gi;
   generate
      for (gi = 0; gi < N_RD - 1; gi++) begin : g_hold
         logic [7:0] r_byte;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_byte <= 8'h00;
            else if (w_capture && (r_rd_idx == 2'(gi)))
               r_byte <= spi_rd_data[7:0];
         end
      end
   endgenerate

`ifdef PITCH_RD_EN
   logic [15:0] r_pitch;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_yaw   <= 16'h0000;
         r_vld   <= 1'b0;
`ifdef PITCH_RD_EN
         r_pitch <= 16'h0000;
`endif
      end else begin
         r_vld <= w_burst_last;
         if (w_burst_last) begin
`ifdef PITCH_RD_EN
            r_yaw   <= {g_hold[1].r_byte, g_hold[0].r_byte};
            r_pitch <= {spi_rd_data[7:0], g_hold[2].r_byte};
`else
            r_yaw   <= {spi_rd_data[7:0], g_hold[0].r_byte};
`endif
         end
      end
   end

   assign spi_wrt  = r_spi_wrt;
   assign spi_cmd  = r_spi_cmd;
   assign yaw_rt   = r_yaw;
   assign vld      = r_vld;
   assign cfg_done = r_cfg_done;
`ifdef PITCH_RD_EN
   assign pitch_rt = r_pitch;
`endif

endmodule

// File: doc/inert_spi_seq.md
Name: inert_spi_seq

Overview:
Sequencer that owns the SPI monarch port and drives one inertial sensor. After power-up it issues a fixed configuration write sequence. It then services each sensor data-ready interrupt with a burst of register reads and assembles signed 16-bit rate readings. It sits between the SPI monarch and the heading/balance logic, and is the only block that asserts the monarch's write strobe.

Parameters:
PWRUP_W, 16, width of power-up wait counter; wait = 2^PWRUP_W clk cycles before first transaction (benches use 4)
CFG0, 16'h0D02, first config word (enable data-ready INT)
CFG1, 16'h1160, second config word (gyro ODR/range)
CFG2, 16'h1440, third config word (rounding on)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
INT  in  1  sensor data-ready, asynchronous to clk, active high
spi_done  in  1  monarch transaction-complete level (cleared by monarch on the wrt edge)
spi_rd_data  in  16  monarch read data; low byte valid when spi_done high
spi_wrt  out  1  single-cycle transaction start to monarch
spi_cmd  out  16  command word to monarch; stable from spi_wrt until spi_done
yaw_rt  out  16  signed yaw rate {YAWH,YAWL}
vld  out  1  one-cycle pulse: new reading(s) on outputs
cfg_done  out  1  level: configuration complete

Behaviour:
- Reset, asynchronous, active-low, on clk. Reset values: spi_wrt=0, spi_cmd=16'h0000, yaw_rt=0, vld=0, cfg_done=0, state=PWRUP, power-up counter=0, INT synchroniser=0.
- INT passes through a 2-flop synchroniser, then a third flop. int_rise = sync & ~prev.
- A pending flag sets on int_rise and clears when the READ burst starts. A rise during a burst is remembered once; multiple rises collapse to one.
- Issue rule: spi_wrt pulses exactly one cycle, with spi_cmd loaded in the same cycle. The next state waits for spi_done==1 on a cycle after the pulse. The cycle of the pulse never counts as done, because stale done is still high then.
- States:
  - PWRUP: counter increments each clk. When all ones -> CFG with index 0.
  - CFG: issue CFGn -> CFGW.
  - CFGW: on spi_done, index++. After CFG2 -> IDLE and set cfg_done (held until reset). Otherwise -> CFG.
  - IDLE: if pending -> RD with cmd 16'hA600 (read YAWL; bit15=read, addr in [14:8]).
  - RD: issue the current read cmd -> RDW.
  - RDW: on spi_done, capture spi_rd_data[7:0] into the low or high holding byte.
    - After YAWL -> RD with 16'hA700.
    - After YAWH -> IDLE; update yaw_rt={H,L} and pulse vld in the same cycle.
- yaw_rt updates atomically; partial bytes never appear on outputs.
- Latency: int_rise to first spi_wrt = 2 clk (pending set, IDLE->RD).
- INT events before cfg_done: a rise during PWRUP/CFG sets pending and is serviced immediately after configuration.
- spi_done stuck low: no timeout; the sequencer waits indefinitely.
- Reset mid-transaction returns to PWRUP with the full wait; a partial burst is discarded.

Optional Feature:
PITCH_RD_EN.
- Defined: adds output pitch_rt[15:0] (reset 0). The burst extends to read PITCHL 16'hA200 and PITCHH 16'hA300 after YAWH. yaw_rt and pitch_rt update together, with one vld pulse after PITCHH.
- Undefined: no pitch_rt port; the burst is two reads.

Test Plan:
1. PWRUP_W=4, monarch model returns done 8 clk after wrt -> no spi_wrt for the first 16 clk; then spi_cmd 0D02, 1160, 1440 in order, each a single-cycle pulse; cfg_done rises after the third done.
2. After cfg_done, pulse INT; model returns 0x00CD then 0x00AB -> cmds A600 then A700; yaw_rt=16'hABCD with a single vld pulse; first wrt 2 clk after the synchronised rise.
3. Model returns 0x0034 and 0x00FF -> yaw_rt=16'hFF34 (negative rate); high byte of spi_rd_data ignored (drive 0x5A).
4. Two INT pulses during one burst, plus one during configuration -> exactly one extra burst after each; no lost or duplicated vld.
5. Assert rst_n low in the middle of the YAWH read -> all outputs at reset values; full power-up and configuration repeat; yaw_rt unchanged from 0 until a new complete burst.
6. PITCH_RD_EN defined: INT -> cmds A600, A700, A200, A300; returns CD, AB, 34, 12 -> yaw_rt=ABCD, pitch_rt=1234, single vld.
